// File: rtl/score_seg_renderer_if.sv
// Pixel-stream and control bundle between the position counters, the
// seven-segment score renderer and the RGB mux.
interface score_seg_renderer_if #(
    parameter int unsigned N_DIGITS = 2
);
    logic                    frame_start;
    logic                    pix_valid;
    logic [9:0]              x;
    logic [9:0]              y;
    logic [9:0]              start_x;
    logic [9:0]              start_y;
    logic [4*N_DIGITS-1:0]   value;
    logic                    lz_blank;
    logic                    blink_en;
    logic                    display;
    logic                    display_valid;
    logic                    changed;

    modport master (
        output frame_start, pix_valid, x, y, start_x, start_y, value, lz_blank, blink_en,
        input  display, display_valid, changed
    );

    modport slave (
        input  frame_start, pix_valid, x, y, start_x, start_y, value, lz_blank, blink_en,
        output display, display_valid, changed
    );
endinterface

// File: rtl/score_seg_renderer.sv
// Two-stage seven-segment renderer for the score overlay: frame-latched
// shadow registers, constant-pitch cell decode, then segment hit test.
module score_seg_renderer #(
    parameter int unsigned N_DIGITS     = 2,
    parameter int unsigned SEG_T        = 4,
    parameter int unsigned GAP          = 4,
    parameter int unsigned HEX_MODE     = 0,
    parameter int unsigned BLINK_FRAMES = 60,
    parameter int unsigned BLINK_DIV    = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    score_seg_renderer_if.slave  bus
);
    localparam int unsigned T    = SEG_T;
    localparam int unsigned P    = 6 * T + GAP;
    localparam int unsigned SPAN = N_DIGITS * P;
    localparam int unsigned CW   = 11;
    localparam int unsigned KW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    // Frame-latched shadow state
    logic [4*N_DIGITS-1:0] r_value;
    logic [9:0]            r_sx;
    logic [9:0]            r_sy;
    logic                  r_lz;
    logic [7:0]            r_blink_cnt;

    // Stage-1 pipeline registers
    logic                  r_s1_valid;
    logic                  r_s1_draw;
    logic [CW-1:0]         r_s1_cx;
    logic [CW-1:0]         r_s1_dy;
    logic [3:0]            r_s1_code;

    logic [CW-1:0]         w_dx;
    logic [CW-1:0]         w_dy;
    logic [CW-1:0]         w_cx;
    logic [KW-1:0]         w_k;
    logic [KW-1:0]         w_dig;
    logic                  w_in;
    logic                  w_gap;
    logic                  w_hide;
    logic                  w_lzb;
    logic                  w_zero_above;
    logic                  w_val_diff;
    logic [3:0]            w_code;
    logic [N_DIGITS-1:0]   w_lzmask;
    logic [6:0]            w_seg;
    logic [6:0]            w_hit;

    function automatic logic in_rng(input logic [CW-1:0] v, input int unsigned lo,
                                    input int unsigned hi);
        return (v >= CW'(lo)) && (v < CW'(hi));
    endfunction

    // Signed-safe offsets: a negative result sets bit 10, so x < sx never wraps in
    assign w_dx   = {1'b0, bus.x} - {1'b0, r_sx};
    assign w_dy   = {1'b0, bus.y} - {1'b0, r_sy};
    assign w_in   = !w_dx[CW-1] && (w_dx < CW'(SPAN)) && !w_dy[CW-1] && (w_dy < CW'(9 * T));
    assign w_gap  = (w_cx >= CW'(6 * T));
    assign w_dig  = KW'(N_DIGITS - 1) - w_k;
    assign w_hide = bus.blink_en && (r_blink_cnt != 8'd0) && r_blink_cnt[BLINK_DIV];
    assign w_val_diff = (bus.value != r_value);

    // Cell index and in-cell column by comparison against constant multiples of P
    always_comb begin
        w_k  = '0;
        w_cx = w_dx;
        for (int i = 1; i < int'(N_DIGITS); i++) begin
            if (w_dx >= CW'(i * P)) begin
                w_k  = KW'(i);
                w_cx = w_dx - CW'(i * P);
            end
        end
    end

    // A digit is a leading zero if it and every digit above it are zero
    always_comb begin
        w_zero_above = r_lz;
        w_lzmask     = '0;
        for (int i = int'(N_DIGITS) - 1; i >= 1; i--) begin
            w_zero_above = w_zero_above & (r_value[4*i +: 4] == 4'd0);
            w_lzmask[i]  = w_zero_above;
        end
    end

    always_comb begin
        w_code = '0;
        w_lzb  = 1'b0;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (w_dig == KW'(i)) begin
                w_code = r_value[4*i +: 4];
                w_lzb  = w_lzmask[i];
            end
        end
    end

    // Glyph table, segments ordered {a,b,c,d,e,f,g}
    always_comb begin
        w_seg = '0;
        case (r_s1_code)
            4'h0: w_seg = 7'b1111110;
            4'h1: w_seg = 7'b0110000;
            4'h2: w_seg = 7'b1101101;
            4'h3: w_seg = 7'b1111001;
            4'h4: w_seg = 7'b0110011;
            4'h5: w_seg = 7'b1011011;
            4'h6: w_seg = 7'b1011111;
            4'h7: w_seg = 7'b1110000;
            4'h8: w_seg = 7'b1111111;
            4'h9: w_seg = 7'b1111011;
            4'hA: w_seg = 7'b1110111;
            4'hB: w_seg = 7'b0011111;
            4'hC: w_seg = 7'b1001110;
            4'hD: w_seg = 7'b0111101;
            4'hE: w_seg = 7'b1001111;
            default: w_seg = 7'b1000111;
        endcase
        if ((HEX_MODE == 0) && (r_s1_code >= 4'hA)) begin
            w_seg = '0;
        end
    end

    assign w_hit = {
        in_rng(r_s1_cx, T,     5 * T) && in_rng(r_s1_dy, 0,     T),
        in_rng(r_s1_cx, 5 * T, 6 * T) && in_rng(r_s1_dy, T,     4 * T),
        in_rng(r_s1_cx, 5 * T, 6 * T) && in_rng(r_s1_dy, 5 * T, 8 * T),
        in_rng(r_s1_cx, T,     5 * T) && in_rng(r_s1_dy, 8 * T, 9 * T),
        in_rng(r_s1_cx, 0,     T)     && in_rng(r_s1_dy, 5 * T, 8 * T),
        in_rng(r_s1_cx, 0,     T)     && in_rng(r_s1_dy, T,     4 * T),
        in_rng(r_s1_cx, T,     5 * T) && in_rng(r_s1_dy, 4 * T, 5 * T)
    };

    // Shadow latch and blink counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_value     <= '0;
            r_sx        <= '0;
            r_sy        <= '0;
            r_lz        <= 1'b0;
            r_blink_cnt <= '0;
            bus.changed <= 1'b0;
        end else begin
            bus.changed <= 1'b0;
            if (bus.frame_start) begin
                r_value     <= bus.value;
                r_sx        <= bus.start_x;
                r_sy        <= bus.start_y;
                r_lz        <= bus.lz_blank;
                bus.changed <= w_val_diff;
                if (w_val_diff && bus.blink_en) begin
                    r_blink_cnt <= 8'(BLINK_FRAMES);
                end else if (r_blink_cnt != 8'd0) begin
                    r_blink_cnt <= r_blink_cnt - 8'd1;
                end
            end
        end
    end

    // Two-stage pixel pipeline; digit code is captured so a latch mid-flight cannot tear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid        <= 1'b0;
            r_s1_draw         <= 1'b0;
            r_s1_cx           <= '0;
            r_s1_dy           <= '0;
            r_s1_code         <= '0;
            bus.display       <= 1'b0;
            bus.display_valid <= 1'b0;
        end else begin
            r_s1_valid        <= bus.pix_valid;
            r_s1_draw         <= bus.pix_valid && w_in && !w_gap && !w_lzb && !w_hide;
            r_s1_cx           <= w_cx;
            r_s1_dy           <= w_dy;
            r_s1_code         <= w_code;
            bus.display       <= r_s1_draw && (|(w_seg & w_hit));
            bus.display_valid <= r_s1_valid;
        end
    end
endmodule

// File: tb/tb_score_seg_renderer.sv
// Directed bench for score_seg_renderer: one decimal-only and one hex instance
// share stimulus; expected pixels are hand-derived from the glyph geometry (T=4, P=28).
module tb_score_seg_renderer;
    logic       clk = 1'b0;
    logic       reset;
    logic       frame_start;
    logic       pix_valid;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] start_x;
    logic [9:0] start_y;
    logic [7:0] value;
    logic       lz_blank;
    logic       blink_en;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    score_seg_renderer_if #(.N_DIGITS(2)) u_if0 ();
    score_seg_renderer_if #(.N_DIGITS(2)) u_if1 ();

    assign u_if0.frame_start = frame_start;
    assign u_if0.pix_valid   = pix_valid;
    assign u_if0.x           = x;
    assign u_if0.y           = y;
    assign u_if0.start_x     = start_x;
    assign u_if0.start_y     = start_y;
    assign u_if0.value       = value;
    assign u_if0.lz_blank    = lz_blank;
    assign u_if0.blink_en    = blink_en;
    assign u_if1.frame_start = frame_start;
    assign u_if1.pix_valid   = pix_valid;
    assign u_if1.x           = x;
    assign u_if1.y           = y;
    assign u_if1.start_x     = start_x;
    assign u_if1.start_y     = start_y;
    assign u_if1.value       = value;
    assign u_if1.lz_blank    = lz_blank;
    assign u_if1.blink_en    = blink_en;

    score_seg_renderer #(.N_DIGITS(2), .SEG_T(4), .GAP(4), .HEX_MODE(0)) u_dut0 (
        .clk(clk), .reset(reset), .bus(u_if0)
    );
    score_seg_renderer #(.N_DIGITS(2), .SEG_T(4), .GAP(4), .HEX_MODE(1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(u_if1)
    );

    // One isolated pixel; returns what both renderers produced for it
    task automatic pix(input int px, input int py, output logic d0, output logic d1,
                       output logic dv);
        @(negedge clk);
        x = 10'(px);
        y = 10'(py);
        pix_valid = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0;
        @(negedge clk);
        d0 = u_if0.display;
        d1 = u_if1.display;
        dv = u_if0.display_valid;
    endtask

    task automatic frame(input logic [7:0] v, input int sx, input int sy, input logic lz,
                         output logic chg);
        @(negedge clk);
        value       = v;
        start_x     = 10'(sx);
        start_y     = 10'(sy);
        lz_blank    = lz;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chg = u_if0.changed;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({u_if0.display, u_if0.display_valid, u_if0.changed} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 000",
                     {u_if0.display, u_if0.display_valid, u_if0.changed});
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({u_if1.display, u_if1.display_valid, u_if1.changed} !== 3'b000) begin
            errors++;
            $display("FAIL post_reset_idle: got %b want 000",
                     {u_if1.display, u_if1.display_valid, u_if1.changed});
        end
    endtask

    task automatic test_basic();
        logic chg, d0, d1, dv;
        int tbl [15][3] = '{
            '{104, 20, 1}, '{103, 20, 0}, '{119, 20, 1}, '{120, 20, 0}, '{104, 23, 1},
            '{104, 24, 0}, '{104, 19, 0}, '{112, 38, 0}, '{134, 38, 1}, '{104, 55, 1},
            '{104, 56, 0}, '{151, 24, 1}, '{152, 24, 0}, '{100, 24, 1}, '{ 99, 24, 0}
        };
        frame(8'h08, 100, 20, 1'b0, chg);
        checks++;
        if (chg !== 1'b1) begin
            errors++;
            $display("FAIL changed_pulse: got %b want 1", chg);
        end
        @(negedge clk);
        checks++;
        if (u_if0.changed !== 1'b0) begin
            errors++;
            $display("FAIL changed_one_cycle: got %b want 0", u_if0.changed);
        end
        // Latency: nothing one cycle after the pixel, result two cycles after
        x = 10'd104;
        y = 10'd20;
        pix_valid = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0;
        checks++;
        if ({u_if0.display_valid, u_if0.display} !== 2'b00) begin
            errors++;
            $display("FAIL latency_early: got %b want 00", {u_if0.display_valid, u_if0.display});
        end
        @(negedge clk);
        checks++;
        if ({u_if0.display_valid, u_if0.display} !== 2'b11) begin
            errors++;
            $display("FAIL latency_2cyc: got %b want 11", {u_if0.display_valid, u_if0.display});
        end
        foreach (tbl[i]) begin
            pix(tbl[i][0], tbl[i][1], d0, d1, dv);
            checks++;
            if ({dv, d0} !== {1'b1, 1'(tbl[i][2])}) begin
                errors++;
                $display("FAIL basic_pix(%0d,%0d): got valid/display %b%b want 1%0d",
                         tbl[i][0], tbl[i][1], dv, d0, tbl[i][2]);
            end
        end
    endtask

    // Back-to-back scan of row dy=24 (e/c segments) through the "08"
    task automatic test_back_to_back();
        logic exp;
        int   xx;
        for (int i = 0; i < 67; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                xx  = 96 + i - 2;
                exp = ((xx >= 100) && (xx < 104)) || ((xx >= 120) && (xx < 124)) ||
                      ((xx >= 128) && (xx < 132)) || ((xx >= 148) && (xx < 152));
                checks++;
                if (u_if0.display !== exp) begin
                    errors++;
                    $display("FAIL scan_x%0d: got %b want %b", xx, u_if0.display, exp);
                end
            end
            if (i < 65) begin
                x = 10'(96 + i);
                y = 10'd44;
                pix_valid = 1'b1;
            end else begin
                pix_valid = 1'b0;
            end
        end
    endtask

    task automatic test_lz_blank();
        logic chg, d0, d1, dv;
        int t5 [9][3] = '{
            '{104, 20, 0}, '{100, 24, 0}, '{132, 20, 1}, '{148, 24, 0}, '{128, 24, 1},
            '{129, 44, 0}, '{148, 44, 1}, '{134, 38, 1}, '{132, 52, 1}
        };
        int t0 [4][3] = '{ '{132, 20, 1}, '{104, 20, 0}, '{134, 38, 0}, '{148, 24, 1} };
        frame(8'h05, 100, 20, 1'b1, chg);
        foreach (t5[i]) begin
            pix(t5[i][0], t5[i][1], d0, d1, dv);
            checks++;
            if (d0 !== 1'(t5[i][2])) begin
                errors++;
                $display("FAIL lz_05(%0d,%0d): got %b want %0d", t5[i][0], t5[i][1], d0, t5[i][2]);
            end
        end
        frame(8'h00, 100, 20, 1'b1, chg);
        foreach (t0[i]) begin
            pix(t0[i][0], t0[i][1], d0, d1, dv);
            checks++;
            if (d0 !== 1'(t0[i][2])) begin
                errors++;
                $display("FAIL lz_00(%0d,%0d): got %b want %0d", t0[i][0], t0[i][1], d0, t0[i][2]);
            end
        end
    endtask

    // Probe pixel (129,44) is segment e of digit 0: dark for "5", lit for "6"
    task automatic test_blink();
        logic chg, d0, d1, dv, exp;
        int   cnt;
        blink_en = 1'b0;
        frame(8'h05, 100, 20, 1'b0, chg);
        blink_en = 1'b1;
        value = 8'h06;
        pix(129, 44, d0, d1, dv);
        checks++;
        if (d0 !== 1'b0) begin
            errors++;
            $display("FAIL no_tearing: got %b want 0", d0);
        end
        frame(8'h06, 100, 20, 1'b0, chg);
        checks++;
        if (chg !== 1'b1) begin
            errors++;
            $display("FAIL blink_changed: got %b want 1", chg);
        end
        cnt = 60;
        for (int f = 0; f < 63; f++) begin
            pix(129, 44, d0, d1, dv);
            exp = (cnt == 0) || (((cnt >> 3) & 1) == 0);
            checks++;
            if (d0 !== exp) begin
                errors++;
                $display("FAIL blink_cnt%0d: got %b want %b", cnt, d0, exp);
            end
            frame(8'h06, 100, 20, 1'b0, chg);
            checks++;
            if (chg !== 1'b0) begin
                errors++;
                $display("FAIL blink_nochange_f%0d: got %b want 0", f, chg);
            end
            if (cnt > 0) cnt--;
        end
        blink_en = 1'b0;
    endtask

    task automatic test_hex();
        logic chg, d0, d1, dv;
        int tbl [5][4] = '{
            '{132, 20, 0, 1}, '{132, 52, 0, 0}, '{134, 38, 0, 1}, '{129, 24, 0, 1},
            '{104, 20, 1, 1}
        };
        frame(8'h0A, 100, 20, 1'b0, chg);
        foreach (tbl[i]) begin
            pix(tbl[i][0], tbl[i][1], d0, d1, dv);
            checks++;
            if ({d0, d1} !== {1'(tbl[i][2]), 1'(tbl[i][3])}) begin
                errors++;
                $display("FAIL hex_A(%0d,%0d): got dec/hex %b%b want %0d%0d",
                         tbl[i][0], tbl[i][1], d0, d1, tbl[i][2], tbl[i][3]);
            end
        end
    endtask

    task automatic test_wrap_gap();
        logic chg, d0, d1, dv;
        int rows [5] = '{20, 24, 38, 44, 55};
        frame(8'h08, 1010, 20, 1'b0, chg);
        pix(1023, 20, d0, d1, dv);
        checks++;
        if (d0 !== 1'b1) begin
            errors++;
            $display("FAIL wrap_edge_1023: got %b want 1", d0);
        end
        for (int xx = 0; xx <= 20; xx++) begin
            pix(xx, 20, d0, d1, dv);
            checks++;
            if (d0 !== 1'b0) begin
                errors++;
                $display("FAIL nowrap_x%0d: got %b want 0", xx, d0);
            end
        end
        frame(8'h88, 100, 20, 1'b0, chg);
        foreach (rows[r]) begin
            for (int xx = 124; xx < 128; xx++) begin
                pix(xx, rows[r], d0, d1, dv);
                checks++;
                if ((d0 | d1) !== 1'b0) begin
                    errors++;
                    $display("FAIL gap(%0d,%0d): got %b want 0", xx, rows[r], d0 | d1);
                end
            end
        end
        pix(123, 24, d0, d1, dv);
        checks++;
        if (d0 !== 1'b1) begin
            errors++;
            $display("FAIL gap_left_neighbour: got %b want 1", d0);
        end
    endtask

    task automatic test_reset_mid();
        logic chg, d0, d1, dv;
        // frame_start and pix_valid together: pixel uses the old origin (100,20)
        @(negedge clk);
        start_x = 10'd500;
        frame_start = 1'b1;
        x = 10'd104;
        y = 10'd20;
        pix_valid = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        pix_valid = 1'b0;
        checks++;
        if (u_if0.changed !== 1'b0) begin
            errors++;
            $display("FAIL same_value_no_change: got %b want 0", u_if0.changed);
        end
        @(negedge clk);
        checks++;
        if (u_if0.display !== 1'b1) begin
            errors++;
            $display("FAIL coincident_old_shadow: got %b want 1", u_if0.display);
        end
        pix(104, 20, d0, d1, dv);
        checks++;
        if (d0 !== 1'b0) begin
            errors++;
            $display("FAIL new_origin_applied: got %b want 0", d0);
        end
        frame(8'h88, 100, 20, 1'b0, chg);
        @(negedge clk);
        x = 10'd104;
        y = 10'd20;
        pix_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({u_if0.display_valid, u_if0.display} !== 2'b11) begin
            errors++;
            $display("FAIL stream_before_reset: got %b want 11",
                     {u_if0.display_valid, u_if0.display});
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({u_if0.display_valid, u_if0.display, u_if1.display} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset_clear: got %b want 000",
                     {u_if0.display_valid, u_if0.display, u_if1.display});
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({u_if0.display_valid, u_if0.display} !== 2'b10) begin
            errors++;
            $display("FAIL after_reset_shadow0: got %b want 10",
                     {u_if0.display_valid, u_if0.display});
        end
        pix_valid = 1'b0;
        frame(8'h88, 100, 20, 1'b0, chg);
        checks++;
        if (chg !== 1'b1) begin
            errors++;
            $display("FAIL changed_after_reset: got %b want 1", chg);
        end
        pix(104, 20, d0, d1, dv);
        checks++;
        if (d0 !== 1'b1) begin
            errors++;
            $display("FAIL redraw_after_reset: got %b want 1", d0);
        end
    endtask

    initial begin
        reset       = 1'b1;
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        x           = '0;
        y           = '0;
        start_x     = '0;
        start_y     = '0;
        value       = '0;
        lz_blank    = 1'b0;
        blink_en    = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_lz_blank();
        test_blink();
        test_hex();
        test_wrap_gap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not complete, checks %0d", checks);
        $fatal(1);
    end
endmodule
